// File: rtl/dff_en.sv
// dff_en: N-bit state register with synchronous reset, synchronous clear
// and stall (hold). Shared primitive for FSM state, pipeline latches and
// control flags; instantiated positionally as (clk, rst_n, clear, stall, d, q).
// Note: rst_n is active-high despite its name and is only sampled on clk.
module dff_en #(
  parameter int           N       = 1,
  parameter logic [N-1:0] DEFAULT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         stall,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // A zero-width register has no meaning; stop elaboration early.
  generate
    if (N < 1) begin : g_bad_width
      $error("dff_en: N must be >= 1");
    end
  endgenerate

  // Single edge-triggered update; priority is reset > clear > stall > load.
  // Nothing here is combinational, so between-edge activity on d/clear/stall
  // never reaches q.
  always_ff @(posedge clk) begin
    if (rst_n)       q <= DEFAULT;
    else if (clear)  q <= DEFAULT;
    else if (!stall) q <= d;
  end

endmodule

// File: tb/tb_dff_en.sv
// tb_dff_en: directed vectors for three dff_en configurations. The driver
// applies inputs on the falling edge and queues the value q must hold after
// the following rising edge; a monitor pops and compares just after each
// rising edge.
module tb_dff_en;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: N=4, DEFAULT=0
  logic       rst4, clr4, stl4;
  logic [3:0] d4, q4;
  // instance 1: N=8, DEFAULT=8'h3C
  logic       rst8, clr8, stl8;
  logic [7:0] d8, q8;
  // instance 2: N=64, DEFAULT=64'h8000_0000
  logic        rst64, clr64, stl64;
  logic [63:0] d64, q64;

  dff_en #(.N(4), .DEFAULT(4'h0)) u_d4 (
    .clk(clk), .rst_n(rst4), .clear(clr4), .stall(stl4), .d(d4), .q(q4));
  dff_en #(.N(8), .DEFAULT(8'h3C)) u_d8 (
    .clk(clk), .rst_n(rst8), .clear(clr8), .stall(stl8), .d(d8), .q(q8));
  dff_en #(.N(64), .DEFAULT(64'h8000_0000)) u_d64 (
    .clk(clk), .rst_n(rst64), .clear(clr64), .stall(stl64), .d(d64), .q(q64));

  typedef struct {
    int          id;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Monitor: one queued expectation per rising edge, sampled 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        exp_t e;
        logic [63:0] act;
        e = sb.pop_front();
        case (e.id)
          0:       act = {60'd0, q4};
          1:       act = {56'd0, q8};
          default: act = q64;
        endcase
        n_total++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic set_in(input int id, input bit r, input bit c, input bit s,
                        input logic [63:0] dv);
    case (id)
      0: begin rst4  = r; clr4  = c; stl4  = s; d4  = dv[3:0]; end
      1: begin rst8  = r; clr8  = c; stl8  = s; d8  = dv[7:0]; end
      default: begin rst64 = r; clr64 = c; stl64 = s; d64 = dv; end
    endcase
  endtask

  // One edge: apply controls and data at the falling edge, queue the
  // expected q after the next rising edge.
  task automatic drive(input int id, input bit r, input bit c, input bit s,
                       input logic [63:0] dv, input logic [63:0] exp,
                       input string nm);
    @(negedge clk);
    set_in(id, r, c, s, dv);
    sb.push_back('{id, exp, nm});
  endtask

  // Same as drive, but d/clear/stall bounce several times before settling
  // one time unit ahead of the rising edge.
  task automatic drive_glitch(input int id, input bit c, input bit s,
                              input logic [63:0] dv, input logic [63:0] exp,
                              input string nm);
    @(negedge clk);
    sb.push_back('{id, exp, nm});
    set_in(id, 1'b0, ~c, ~s, ~dv);
    #1 set_in(id, 1'b0, 1'b1, 1'b0, 64'h5);
    #1 set_in(id, 1'b0, 1'b0, 1'b1, 64'hA);
    #1 set_in(id, 1'b0, 1'b0, 1'b0, 64'hC);
    #1 set_in(id, 1'b0, c, s, dv);
  endtask

  initial begin
    // all instances held in reset through the first edge (unchecked, q is X before)
    set_in(0, 1'b1, 1'b0, 1'b0, 64'hA);
    set_in(1, 1'b1, 1'b0, 1'b0, 64'h0);
    set_in(2, 1'b1, 1'b0, 1'b0, 64'h0);

    // reset with d=A for two more edges, then release
    drive(0, 1, 0, 0, 64'hA, 64'h0, "rst4_edge1");
    drive(0, 1, 0, 0, 64'hA, 64'h0, "rst4_edge2");
    drive(0, 0, 0, 0, 64'hA, 64'hA, "rst4_release");

    // load sequence, one edge latency
    drive(0, 0, 0, 0, 64'h1, 64'h1, "load_1");
    drive(0, 0, 0, 0, 64'h2, 64'h2, "load_2");
    drive(0, 0, 0, 0, 64'h3, 64'h3, "load_3");
    drive(0, 0, 0, 0, 64'h4, 64'h4, "load_4");

    // stall holds 5 against d=F for three edges
    drive(0, 0, 0, 0, 64'h5, 64'h5, "stall_pre");
    drive(0, 0, 0, 1, 64'hF, 64'h5, "stall_1");
    drive(0, 0, 0, 1, 64'hF, 64'h5, "stall_2");
    drive(0, 0, 0, 1, 64'hF, 64'h5, "stall_3");
    drive(0, 0, 0, 0, 64'hF, 64'hF, "stall_drop");

    // reset beats clear+stall
    drive(0, 1, 1, 1, 64'h7, 64'h0, "rst_over_all");

    // glitches between edges; only settled values count
    drive_glitch(0, 0, 0, 64'h6, 64'h6, "glitch_load");
    drive_glitch(0, 0, 1, 64'h9, 64'h6, "glitch_stall");
    drive_glitch(0, 1, 0, 64'h9, 64'h0, "glitch_clear");
    drive_glitch(0, 0, 0, 64'hB, 64'hB, "glitch_load2");

    // 8-bit, DEFAULT=3C: clear vs stall
    drive(1, 0, 0, 0, 64'h99, 64'h99, "w8_load99");
    drive(1, 0, 1, 1, 64'h55, 64'h3C, "w8_clear_stall");
    drive(1, 0, 0, 0, 64'h99, 64'h99, "w8_reload99");
    drive(1, 0, 1, 0, 64'h55, 64'h3C, "w8_clear_only");
    drive(1, 0, 0, 1, 64'h11, 64'h3C, "w8_stall_hold");
    drive(1, 0, 0, 0, 64'hA5, 64'hA5, "w8_loadA5");
    drive(1, 1, 0, 1, 64'h22, 64'h3C, "w8_rst_over_stall");
    drive(1, 0, 0, 0, 64'h5A, 64'h5A, "w8_after_rst");

    // 64-bit, reset mid-operation
    drive(2, 0, 0, 0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, "w64_load");
    drive(2, 1, 0, 0, 64'h1234, 64'h8000_0000, "w64_mid_rst");
    drive(2, 0, 0, 0, 64'h1, 64'h1, "w64_after_rst");
    drive(2, 0, 0, 0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, "w64_full");
    drive(2, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, "w64_clear");

    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #3;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
